// File: rtl/rename_regfile_mp.sv
// Architectural register file with rename tags: NUM_READ read ports with
// commit forwarding, one rename port, NUM_COMMIT commit ports and a live
// count of renamed registers for dispatch throttling.
module rename_regfile_mp #(
  parameter int unsigned     REG_COUNT  = 32,
  parameter int unsigned     REG_W      = 5,
  parameter int unsigned     DATA_W     = 32,
  parameter int unsigned     TAG_W      = 4,
  parameter logic [TAG_W-1:0] EMPTY_TAG = '0,
  parameter int unsigned     NUM_READ   = 2,
  parameter int unsigned     NUM_COMMIT = 2,
  parameter int unsigned     CNT_W      = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         clear,
  input  logic [NUM_READ*REG_W-1:0]    rd_pos,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ*TAG_W-1:0]    rd_tag,
  input  logic                         rename_en,
  input  logic [REG_W-1:0]             rename_reg,
  input  logic [TAG_W-1:0]             rename_tag,
  input  logic [NUM_COMMIT-1:0]        commit_en,
  input  logic [NUM_COMMIT*REG_W-1:0]  commit_pos,
  input  logic [NUM_COMMIT*DATA_W-1:0] commit_data,
  input  logic [NUM_COMMIT*TAG_W-1:0]  commit_tag,
  output logic [CNT_W-1:0]             pending_count
);

  logic [DATA_W-1:0] r_data [REG_COUNT];
  logic [TAG_W-1:0]  r_tag  [REG_COUNT];
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_data_nxt [REG_COUNT];
  logic [TAG_W-1:0]  w_tag_nxt  [REG_COUNT];
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_upd;

  // Clear acts even when the pipeline is stalled
  assign w_upd = rdy | clear;

  // Read ports: base value, overridden by a matching same-cycle commit.
  // Register 0 is never written, so it always reads 0 / EMPTY_TAG.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [REG_W-1:0]  w_pos;
    logic [DATA_W-1:0] w_data;
    logic [TAG_W-1:0]  w_tag;

    assign w_pos = rd_pos[k*REG_W +: REG_W];

    // Youngest matching commit wins (later loop iterations override)
    always_comb begin
      w_data = r_data[w_pos];
      w_tag  = r_tag[w_pos];
      if (r_tag[w_pos] != EMPTY_TAG) begin
        for (int unsigned j = 0; j < NUM_COMMIT; j++) begin
          if (commit_en[j] &&
              commit_pos[j*REG_W +: REG_W] == w_pos &&
              commit_tag[j*TAG_W +: TAG_W] == r_tag[w_pos]) begin
            w_data = commit_data[j*DATA_W +: DATA_W];
            w_tag  = EMPTY_TAG;
          end
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
    assign rd_tag[k*TAG_W +: TAG_W]    = w_tag;
  end

  // Next state: commits in ascending order, then clear or rename, then popcount
  always_comb begin
    w_data_nxt = r_data;
    w_tag_nxt  = r_tag;
    for (int unsigned j = 0; j < NUM_COMMIT; j++) begin
      if (commit_en[j] && commit_pos[j*REG_W +: REG_W] != '0) begin
        w_data_nxt[commit_pos[j*REG_W +: REG_W]] = commit_data[j*DATA_W +: DATA_W];
        if (r_tag[commit_pos[j*REG_W +: REG_W]] == commit_tag[j*TAG_W +: TAG_W]) begin
          w_tag_nxt[commit_pos[j*REG_W +: REG_W]] = EMPTY_TAG;
        end
      end
    end
    if (clear) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        w_tag_nxt[REG_W'(i)] = EMPTY_TAG;
      end
    end else if (rename_en && rename_reg != '0) begin
      w_tag_nxt[rename_reg] = rename_tag;
    end
    w_cnt_nxt = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (w_tag_nxt[REG_W'(i)] != EMPTY_TAG) begin
        w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      end
    end
  end

  // State registers; hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        r_data[REG_W'(i)] <= '0;
        r_tag[REG_W'(i)]  <= EMPTY_TAG;
      end
      r_cnt <= '0;
    end else if (w_upd) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        r_data[REG_W'(i)] <= w_data_nxt[REG_W'(i)];
        r_tag[REG_W'(i)]  <= w_tag_nxt[REG_W'(i)];
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  assign pending_count = r_cnt;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Scoreboard bench for rename_regfile_mp: stimulus queues expected read /
// count values, a monitor pops and compares them against the DUT outputs.
module tb_rename_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic [9:0]  rd_pos;
  logic [63:0] rd_data;
  logic [7:0]  rd_tag;
  logic        rename_en;
  logic [4:0]  rename_reg;
  logic [3:0]  rename_tag;
  logic [1:0]  commit_en;
  logic [9:0]  commit_pos;
  logic [63:0] commit_data;
  logic [7:0]  commit_tag;
  logic [5:0]  pending_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0: read port, 1: pending_count
    int          port;
    logic [31:0] data;
    logic [3:0]  tag;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  event ev_sample;

  rename_regfile_mp dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .rd_pos(rd_pos), .rd_data(rd_data), .rd_tag(rd_tag),
    .rename_en(rename_en), .rename_reg(rename_reg), .rename_tag(rename_tag),
    .commit_en(commit_en), .commit_pos(commit_pos),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation when the stimulus samples
  initial begin
    exp_t e;
    logic [31:0] got_d;
    logic [3:0]  got_t;
    forever begin
      @(ev_sample);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (e.kind == 0) begin
          got_d = rd_data[e.port*32 +: 32];
          got_t = rd_tag[e.port*4 +: 4];
          if (got_d !== e.data || got_t !== e.tag) begin
            n_errors++;
            $display("FAIL %s: got data=%h tag=%0d, expected data=%h tag=%0d",
                     e.name, got_d, got_t, e.data, e.tag);
          end
        end else begin
          if (pending_count !== e.cnt) begin
            n_errors++;
            $display("FAIL %s: got pending_count=%0d, expected %0d",
                     e.name, pending_count, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  task automatic clr_in();
    rename_en   = 1'b0;
    rename_reg  = '0;
    rename_tag  = '0;
    commit_en   = '0;
    commit_pos  = '0;
    commit_data = '0;
    commit_tag  = '0;
    clear       = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [4:0] p);
    rd_pos[k*5 +: 5] = p;
  endtask

  task automatic do_rename(input logic [4:0] r, input logic [3:0] t);
    rename_en  = 1'b1;
    rename_reg = r;
    rename_tag = t;
  endtask

  task automatic set_commit(input int j, input logic [4:0] p, input logic [31:0] d,
                            input logic [3:0] t);
    commit_en[j]          = 1'b1;
    commit_pos[j*5 +: 5]  = p;
    commit_data[j*32 +: 32] = d;
    commit_tag[j*4 +: 4]  = t;
  endtask

  task automatic exp_rd(input string name, input int k, input logic [31:0] d,
                        input logic [3:0] t);
    exp_t e;
    e.name = name; e.kind = 0; e.port = k; e.data = d; e.tag = t; e.cnt = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_cnt(input string name, input logic [5:0] c);
    exp_t e;
    e.name = name; e.kind = 1; e.port = 0; e.data = '0; e.tag = '0; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> ev_sample;
    #1;
  endtask

  // Apply current inputs on the next rising edge, then clear them at negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rd_pos = '0;
    clr_in();

    // Reset state
    set_rd(0, 5'd5); set_rd(1, 5'd0);
    @(negedge clk);
    exp_rd("reset_x5", 0, 32'h0, 4'd0);
    exp_rd("reset_x0", 1, 32'h0, 4'd0);
    exp_cnt("reset_cnt", 6'd0);
    sample();
    rst = 1'b0;

    // Rename then commit
    do_rename(5'd3, 4'd7);
    cyc();
    set_rd(0, 5'd3);
    exp_rd("ren_x3", 0, 32'h0, 4'd7);
    exp_cnt("ren_cnt", 6'd1);
    sample();
    set_commit(0, 5'd3, 32'hDEADBEEF, 4'd7);
    cyc();
    exp_rd("cmt_x3", 0, 32'hDEADBEEF, 4'd0);
    exp_cnt("cmt_cnt", 6'd0);
    sample();

    // Forwarding of a same-cycle commit
    do_rename(5'd4, 4'd5);
    cyc();
    set_rd(0, 5'd4);
    exp_rd("fwd_pre", 0, 32'h0, 4'd5);
    sample();
    set_commit(1, 5'd4, 32'h1234, 4'd5);
    exp_rd("fwd_same", 0, 32'h1234, 4'd0);
    sample();
    cyc();
    exp_rd("fwd_after", 0, 32'h1234, 4'd0);
    exp_cnt("fwd_cnt", 6'd0);
    sample();

    // Stale commit keeps the newer tag
    do_rename(5'd6, 4'd2);
    cyc();
    do_rename(5'd6, 4'd9);
    cyc();
    exp_cnt("stale_cnt_pre", 6'd1);
    sample();
    set_rd(0, 5'd6);
    set_commit(0, 5'd6, 32'hAA, 4'd2);
    exp_rd("stale_nofwd", 0, 32'h0, 4'd9);
    sample();
    cyc();
    exp_rd("stale_x6", 0, 32'hAA, 4'd9);
    exp_cnt("stale_cnt", 6'd1);
    sample();

    // Two commits to one register: higher port wins
    do_rename(5'd8, 4'd3);
    cyc();
    exp_cnt("dup_cnt_pre", 6'd2);
    sample();
    set_rd(1, 5'd8);
    set_commit(0, 5'd8, 32'd1, 4'd3);
    set_commit(1, 5'd8, 32'd2, 4'd3);
    exp_rd("dup_fwd", 1, 32'd2, 4'd0);
    sample();
    cyc();
    exp_rd("dup_x8", 1, 32'd2, 4'd0);
    exp_cnt("dup_cnt", 6'd1);
    sample();

    // Rename overrides same-cycle matching commit's tag clear
    do_rename(5'd9, 4'd4);
    cyc();
    exp_cnt("rvc_cnt_pre", 6'd2);
    sample();
    do_rename(5'd9, 4'd4);
    set_commit(0, 5'd9, 32'h77, 4'd4);
    cyc();
    set_rd(0, 5'd9);
    exp_rd("rvc_x9", 0, 32'h77, 4'd4);
    exp_cnt("rvc_cnt", 6'd2);
    sample();

    // Stall and clear
    do_rename(5'd1, 4'd1); cyc();
    do_rename(5'd2, 4'd2); cyc();
    do_rename(5'd3, 4'd3); cyc();
    exp_cnt("clr_cnt_pre", 6'd5);
    sample();
    rdy = 1'b0;
    do_rename(5'd5, 4'd6);
    cyc();
    set_rd(0, 5'd5);
    exp_rd("stall_x5", 0, 32'h0, 4'd0);
    exp_cnt("stall_cnt", 6'd5);
    sample();
    clear = 1'b1;
    set_commit(0, 5'd2, 32'h55, 4'd12);
    do_rename(5'd7, 4'd8);
    cyc();
    set_rd(0, 5'd2); set_rd(1, 5'd1);
    exp_rd("clr_x2", 0, 32'h55, 4'd0);
    exp_rd("clr_x1", 1, 32'h0, 4'd0);
    exp_cnt("clr_cnt", 6'd0);
    sample();
    set_rd(0, 5'd7); set_rd(1, 5'd6);
    exp_rd("clr_x7", 0, 32'h0, 4'd0);
    exp_rd("clr_x6", 1, 32'hAA, 4'd0);
    sample();
    rdy = 1'b1;

    // Register 0 ignores rename and commit
    do_rename(5'd0, 4'd5);
    set_commit(0, 5'd0, 32'h99, 4'd0);
    cyc();
    set_rd(0, 5'd0);
    exp_rd("x0_read", 0, 32'h0, 4'd0);
    exp_cnt("x0_cnt", 6'd0);
    sample();

    // Unrename with EMPTY_TAG
    do_rename(5'd10, 4'd3); cyc();
    exp_cnt("unren_cnt_pre", 6'd1);
    sample();
    do_rename(5'd10, 4'd0); cyc();
    set_rd(0, 5'd10);
    exp_rd("unren_x10", 0, 32'h0, 4'd0);
    exp_cnt("unren_cnt", 6'd0);
    sample();

    // Asynchronous reset mid-cycle
    do_rename(5'd11, 4'd2); cyc();
    exp_cnt("arst_cnt_pre", 6'd1);
    sample();
    rst = 1'b1;
    set_rd(0, 5'd6); set_rd(1, 5'd11);
    exp_rd("arst_x6", 0, 32'h0, 4'd0);
    exp_rd("arst_x11", 1, 32'h0, 4'd0);
    exp_cnt("arst_cnt", 6'd0);
    sample();
    rst = 1'b0;
    do_rename(5'd12, 4'd1); cyc();
    exp_cnt("post_rst_cnt", 6'd1);
    sample();

    #20;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
